// File: rtl/fir_mac_sequencer.sv
// Sequencer for a time-multiplexed FIR engine: per accepted sample it writes the buffer,
// walks all taps through one shared MAC, then waits out the MAC pipeline.
// Optional build macro FIR_MAC_SEQ_FLUSH_EN adds a zero-fill pass over the buffer after clear.
module fir_mac_sequencer #(
  parameter int N_TAPS      = 32,
  parameter int ADDR_WIDTH  = $clog2(N_TAPS),
  parameter int MAC_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  sample_valid_i,
  output logic                  ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH-1:0] coef_addr_o,
  output logic                  mac_en_o,
  output logic                  acc_clr_o,
  output logic                  acc_done_o,
  output logic                  overrun_o
`ifdef FIR_MAC_SEQ_FLUSH_EN
  ,
  output logic                  wr_zero_o
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef FIR_MAC_SEQ_FLUSH_EN
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] RST_STATE = S_FLUSH;
  localparam logic       RST_READY = 1'b0;
`else
  localparam logic [2:0] RST_STATE = S_IDLE;
  localparam logic       RST_READY = 1'b1;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_TAPS - 1);
  localparam int                    CNT_W     = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'((MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0);

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] coef_addr_q, coef_addr_d;
  logic                  mac_en_q, mac_en_d;
  logic                  acc_clr_q, acc_clr_d;
  logic                  acc_done_q, acc_done_d;
  logic                  overrun_q, overrun_d;
`ifdef FIR_MAC_SEQ_FLUSH_EN
  logic                  wr_zero_q, wr_zero_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    coef_addr_d = coef_addr_q;
    mac_en_d    = 1'b0;
    acc_clr_d   = 1'b0;
    acc_done_d  = 1'b0;
    overrun_d   = overrun_q | (sample_valid_i & ~ready_q);
`ifdef FIR_MAC_SEQ_FLUSH_EN
    wr_zero_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (sample_valid_i) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = wr_ptr_q;
          wr_ptr_d  = wrap_inc(wr_ptr_q);
        end else begin
          ready_d = 1'b1;
        end
      end
      // wr_addr_q keeps the newest sample's slot and serves as the tap-walk base.
      S_WRITE: begin
        state_d     = S_RUN;
        mac_en_d    = 1'b1;
        acc_clr_d   = 1'b1;
        rd_addr_d   = wr_addr_q;
        coef_addr_d = '0;
      end
      S_RUN: begin
        if (coef_addr_q != LAST_ADDR) begin
          mac_en_d    = 1'b1;
          coef_addr_d = coef_addr_q + 1'b1;
          rd_addr_d   = (rd_addr_q == '0) ? LAST_ADDR : rd_addr_q - 1'b1;
        end else if (MAC_LATENCY == 0) begin
          state_d    = S_IDLE;
          ready_d    = 1'b1;
          acc_done_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = S_IDLE;
          ready_d    = 1'b1;
          acc_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef FIR_MAC_SEQ_FLUSH_EN
      // Zero-fill pass; ends once the last slot has been written.
      S_FLUSH: begin
        if (wr_en_q && wr_addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_zero_d = 1'b1;
          wr_addr_d = wr_ptr_q;
          wr_ptr_d  = wrap_inc(wr_ptr_q);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q     <= RST_STATE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      ready_q     <= RST_READY;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      coef_addr_q <= '0;
      mac_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_done_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef FIR_MAC_SEQ_FLUSH_EN
      wr_zero_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      coef_addr_q <= coef_addr_d;
      mac_en_q    <= mac_en_d;
      acc_clr_q   <= acc_clr_d;
      acc_done_q  <= acc_done_d;
      overrun_q   <= overrun_d;
`ifdef FIR_MAC_SEQ_FLUSH_EN
      wr_zero_q   <= wr_zero_d;
`endif
    end
  end

  assign ready_o     = ready_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign rd_addr_o   = rd_addr_q;
  assign coef_addr_o = coef_addr_q;
  assign mac_en_o    = mac_en_q;
  assign acc_clr_o   = acc_clr_q;
  assign acc_done_o  = acc_done_q;
  assign overrun_o   = overrun_q;
`ifdef FIR_MAC_SEQ_FLUSH_EN
  assign wr_zero_o   = wr_zero_q;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: dut_a (4 taps, latency 2) and dut_b (5 taps, latency 0).
// Stimulus queues the expected write/MAC/done events; a negedge monitor pops and compares them.
module tb_fir_mac_sequencer;

  typedef struct packed {
    logic       ready, wr_en, wr_zero, mac_en, acc_clr, done, overrun;
    logic [3:0] wr_addr, rd_addr, coef;
  } obs_t;

`ifdef FIR_MAC_SEQ_FLUSH_EN
  localparam logic RST_READY = 1'b0;
`else
  localparam logic RST_READY = 1'b1;
`endif

  logic       clk = 1'b0;
  logic [1:0] clr = 2'b11;
  logic [1:0] sv  = 2'b00;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_ready, a_wr_en, a_mac_en, a_acc_clr, a_done, a_ovr;
  logic [1:0] a_wr_addr, a_rd_addr, a_coef;
  logic       b_ready, b_wr_en, b_mac_en, b_acc_clr, b_done, b_ovr;
  logic [2:0] b_wr_addr, b_rd_addr, b_coef;
`ifdef FIR_MAC_SEQ_FLUSH_EN
  logic       a_wr_zero, b_wr_zero;
`else
  wire        a_wr_zero = 1'b0;
  wire        b_wr_zero = 1'b0;
`endif

  fir_mac_sequencer #(.N_TAPS(4), .MAC_LATENCY(2)) dut_a (
    .clk_i(clk), .clr_i(clr[0]), .sample_valid_i(sv[0]), .ready_o(a_ready),
    .wr_en_o(a_wr_en), .wr_addr_o(a_wr_addr), .rd_addr_o(a_rd_addr), .coef_addr_o(a_coef),
    .mac_en_o(a_mac_en), .acc_clr_o(a_acc_clr), .acc_done_o(a_done), .overrun_o(a_ovr)
`ifdef FIR_MAC_SEQ_FLUSH_EN
    , .wr_zero_o(a_wr_zero)
`endif
  );

  fir_mac_sequencer #(.N_TAPS(5), .MAC_LATENCY(0)) dut_b (
    .clk_i(clk), .clr_i(clr[1]), .sample_valid_i(sv[1]), .ready_o(b_ready),
    .wr_en_o(b_wr_en), .wr_addr_o(b_wr_addr), .rd_addr_o(b_rd_addr), .coef_addr_o(b_coef),
    .mac_en_o(b_mac_en), .acc_clr_o(b_acc_clr), .acc_done_o(b_done), .overrun_o(b_ovr)
`ifdef FIR_MAC_SEQ_FLUSH_EN
    , .wr_zero_o(b_wr_zero)
`endif
  );

  obs_t obs_a, obs_b;
  assign obs_a = {a_ready, a_wr_en, a_wr_zero, a_mac_en, a_acc_clr, a_done, a_ovr,
                  2'b00, a_wr_addr, 2'b00, a_rd_addr, 2'b00, a_coef};
  assign obs_b = {b_ready, b_wr_en, b_wr_zero, b_mac_en, b_acc_clr, b_done, b_ovr,
                  1'b0, b_wr_addr, 1'b0, b_rd_addr, 1'b0, b_coef};

  function automatic obs_t get_obs(input int d);
    return (d == 1) ? obs_b : obs_a;
  endfunction

  function automatic int nt(input int d);
    return (d == 1) ? 5 : 4;
  endfunction

  function automatic int lat(input int d);
    return (d == 1) ? 0 : 2;
  endfunction

  // Event kinds: 0 = sample write, 1 = MAC tap, 2 = done, 3 = flush write.
  function automatic logic [63:0] mk_evt(input int d, input int c, input logic [1:0] kind,
                                         input int a1, input int a2, input logic aclr, input logic rdy);
    return {35'd0, d[0], c[15:0], kind, a1[3:0], a2[3:0], aclr, rdy};
  endfunction

  function automatic logic [63:0] evt_of(input int d, input obs_t o);
    logic [1:0] kind;
    int a1, a2;
    a1 = 0;
    a2 = 0;
    if (o.wr_en) begin
      kind = o.wr_zero ? 2'd3 : 2'd0;
      a1   = int'(o.wr_addr);
    end else if (o.mac_en) begin
      kind = 2'd1;
      a1   = int'(o.rd_addr);
      a2   = int'(o.coef);
    end else begin
      kind = 2'd2;
    end
    return mk_evt(d, cyc, kind, a1, a2, o.acc_clr, o.ready);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      o = get_obs(d);
      if (o.wr_en || o.mac_en || o.done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event dut%0d (cycle %0d): got %h, expected none",
                   d, cyc, evt_of(d, o));
        end else begin
          check($sformatf("event_dut%0d", d), evt_of(d, o), exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  // Strobe in cycle s: write at s+1, taps at s+2.., done at s+N+2+latency.
  task automatic push_seq(input int d, input int base);
    int n, s;
    n = nt(d);
    s = cyc;
    exp_q.push_back(mk_evt(d, s + 1, 2'd0, base, 0, 1'b0, 1'b0));
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk_evt(d, s + 2 + k, 2'd1, (base - k + n) % n, k, k == 0, 1'b0));
    exp_q.push_back(mk_evt(d, s + n + 2 + lat(d), 2'd2, 0, 0, 1'b0, 1'b1));
  endtask

  task automatic do_strobe(input int d, input int base);
    sv[d] = 1'b1;
    push_seq(d, base);
    tick();
    sv[d] = 1'b0;
  endtask

  task automatic do_clr(input int d);
    int c;
    clr[d] = 1'b1;
    tick();
    sv[d] = 1'b0;
    exp_q.delete();
    check("reset_state", 64'(get_obs(d)), 64'({RST_READY, 18'd0}));
    clr[d] = 1'b0;
`ifdef FIR_MAC_SEQ_FLUSH_EN
    c = cyc;
    for (int k = 0; k < nt(d); k++)
      exp_q.push_back(mk_evt(d, c + 1 + k, 2'd3, k, 0, 1'b0, 1'b0));
    wait_n(nt(d) + 1);
    check("flush_then_ready", 64'(get_obs(d).ready), 64'd1);
`else
    c = 0;
`endif
  endtask

  initial begin
    // dut_a: single sample, then a second one after it finishes
    do_clr(0);
    do_strobe(0, 0);
    wait_n(9);
    do_strobe(0, 1);
    wait_n(9);

    // five samples, each issued in the previous done cycle
    do_clr(0);
    for (int i = 0; i < 5; i++) begin
      do_strobe(0, i % 4);
      wait_n(7);
    end
    tick();
    check("no_overrun_back_to_back", 64'(obs_a.overrun), 64'd0);

    // strobe during RUN is dropped and flagged
    do_strobe(0, 1);
    wait_n(2);
    check("overrun_before", 64'(obs_a.overrun), 64'd0);
    sv[0] = 1'b1;
    tick();
    sv[0] = 1'b0;
    check("overrun_set", 64'(obs_a.overrun), 64'd1);
    wait_n(10);
    check("overrun_sticky", 64'(obs_a.overrun), 64'd1);

    // clear mid-RUN together with a strobe: clear wins, pointer restarts at 0
    do_strobe(0, 2);
    wait_n(2);
    sv[0] = 1'b1;
    do_clr(0);
    do_strobe(0, 0);
    wait_n(9);

    // dut_b: 5 taps, no MAC latency
    clr[0] = 1'b1;
    do_clr(1);
    do_strobe(1, 0);
    wait_n(6);
    do_strobe(1, 1);
    wait_n(6);
    do_strobe(1, 2);
    wait_n(8);
    check("b_overrun_clear", 64'(obs_b.overrun), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout (cycle %0d): got no end of stimulus, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Controller for a time-multiplexed FIR tap engine: one shared MAC, one circular sample buffer holding N_TAPS samples, and one coefficient ROM.
- On each accepted input sample it does three things in order:
  - writes the sample into the buffer;
  - walks all taps, newest sample paired with coefficient 0;
  - drains the MAC pipeline and flags the result as valid.
- Sits between the audio sample strobe and the shared buffer/ROM/MAC datapath, including its delay-line registers.

Parameters:
- N_TAPS, 32: number of taps and buffer depth; must be ≥ 2; need not be a power of two.
- ADDR_WIDTH, $clog2(N_TAPS): width of the buffer and coefficient addresses.
- MAC_LATENCY, 2: cycles from the last mac_en_o to the accumulator result being valid; 0 is legal.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- clr_i  in  1  clear; synchronous, active-high.
- sample_valid_i  in  1  single-cycle new-sample strobe; sample data goes straight to the buffer.
- ready_o  out  1  sequencer is idle and accepts sample_valid_i.
- wr_en_o  out  1  buffer write enable.
- wr_addr_o  out  ADDR_WIDTH  buffer write address.
- rd_addr_o  out  ADDR_WIDTH  buffer read address.
- coef_addr_o  out  ADDR_WIDTH  coefficient ROM address.
- mac_en_o  out  1  MAC multiply-accumulate enable.
- acc_clr_o  out  1  MAC loads the product instead of accumulating (first tap).
- acc_done_o  out  1  one-cycle pulse: accumulator holds the finished output.
- overrun_o  out  1  sticky: a sample arrived while busy.

Behaviour:
- All outputs are registered.
- Reset: clr_i high at a rising edge forces the following, regardless of state, including mid-RUN or mid-DRAIN:
  - state = IDLE, wr_ptr = 0;
  - ready_o = 1;
  - all other outputs = 0, addresses = 0, overrun_o = 0.
- FSM states: IDLE, WRITE, RUN, DRAIN.
- IDLE:
  - ready_o = 1.
  - sample_valid_i = 1 → WRITE.
- WRITE (1 cycle):
  - wr_en_o = 1, wr_addr_o = wr_ptr; base latches wr_ptr.
  - wr_ptr advances: wr_ptr = (wr_ptr == N_TAPS-1) ? 0 : wr_ptr+1.
  - Next state → RUN, k = 0.
- RUN (N_TAPS cycles, k = 0..N_TAPS-1):
  - mac_en_o = 1.
  - rd_addr_o = (base − k) mod N_TAPS; wrap is explicit, not a power-of-two mask.
  - coef_addr_o = k.
  - acc_clr_o = 1 only when k = 0.
  - After k = N_TAPS-1 → DRAIN, or straight to the done cycle if MAC_LATENCY = 0.
- DRAIN (MAC_LATENCY cycles): mac_en_o = 0, all enables low.
- Done cycle:
  - acc_done_o = 1 for one cycle, in the same cycle state returns to IDLE with ready_o = 1.
  - A sample presented in this cycle is accepted.
- Timing, with cycle 0 = sample_valid_i high while ready_o high:
  - wr_en_o in cycle 1;
  - mac_en_o in cycles 2..N_TAPS+1;
  - acc_done_o in cycle N_TAPS+2+MAC_LATENCY.
  - Maximum throughput: one sample per N_TAPS+2+MAC_LATENCY cycles.
- Overrun:
  - sample_valid_i high while ready_o low: the sample is dropped and the sequence is unaffected.
  - overrun_o = 1 from the next cycle and stays high until clr_i.
- clr_i and sample_valid_i in the same cycle: clr_i wins and the sample is dropped.
- When not in WRITE/RUN, addresses hold their last values; enables are low.

Optional Feature:
- Macro: FIR_MAC_SEQ_FLUSH_EN.
- Defined:
  - Adds output port wr_zero_o (1 bit).
  - After clr_i deasserts, the FSM enters FLUSH for N_TAPS cycles with wr_en_o = 1, wr_zero_o = 1, wr_addr_o = 0..N_TAPS-1, ready_o = 0.
  - Then → IDLE.
  - sample_valid_i during FLUSH counts as overrun.
  - wr_zero_o = 0 outside FLUSH.
- Not defined: no wr_zero_o port, no FLUSH state; ready_o = 1 the cycle after reset. Buffer contents are left untouched.

Test Plan:
- N_TAPS=4, MAC_LATENCY=2, clr_i then one strobe at cycle 0 →
  - cycle 1: wr_en_o, wr_addr_o = 0;
  - cycles 2–5: mac_en_o, rd_addr_o = 0,3,2,1, coef_addr_o = 0,1,2,3;
  - acc_clr_o in cycle 2 only;
  - cycle 8: acc_done_o = 1 and ready_o = 1.
- Second strobe after the first finishes → wr_addr_o = 1, rd_addr_o = 1,0,3,2.
- Five strobes each issued in the acc_done_o cycle → wr_addr_o = 0,1,2,3,0; back-to-back spacing exactly 8 cycles; overrun_o stays 0.
- Strobe during RUN (cycle 3) → same sequence and acc_done_o cycle as without it; overrun_o = 1 from cycle 4, held until clr_i.
- clr_i during RUN cycle 3 → next cycle mac_en_o = 0, ready_o = 1, overrun_o = 0; next strobe writes address 0.
- N_TAPS=5, MAC_LATENCY=0, strobe after writes to 0,1 → wr_addr_o = 2, rd_addr_o = 2,1,0,4,3, acc_done_o in cycle 7.
- With FIR_MAC_SEQ_FLUSH_EN, N_TAPS=4 → after clr_i: 4 cycles wr_en_o = wr_zero_o = 1 with addresses 0,1,2,3, then ready_o = 1.
